uart_tx_controller: RTL and testbench
=====================================

UART_TX_CONTROLLER -- requirements
Module: uart_tx_controller

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8 (from arch_defs_pkg), giving the frame data width.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 8, giving the TX queue depth; it must be a power of 2 and at least 2.
REQ-003 The block SHALL have parameter ACK_TIMEOUT, default 4, giving the maximum cycles to wait for tx_busy to rise after a start.
REQ-004 The block SHALL have port clk, input, 1 bit: the single system clock.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port wr_en, input, 1 bit: CPU push strobe.
REQ-007 The block SHALL have port wr_data, input, DATA_WIDTH bits: the byte to queue.
REQ-008 The block SHALL have port flush, input, 1 bit: discard all queued bytes.
REQ-009 The block SHALL have port tx_enable, input, 1 bit: permit new frames to start.
REQ-010 The block SHALL have port overflow_clr, input, 1 bit: clear the sticky overflow flag.
REQ-011 The block SHALL have port tx_busy, input, 1 bit: busy_flag from the UART transmitter.
REQ-012 The block SHALL have port tx_start, output, 1 bit: one-cycle start strobe to the transmitter.
REQ-013 The block SHALL have port tx_data, output, DATA_WIDTH bits: the byte presented to the transmitter.
REQ-014 The block SHALL have port fifo_empty, output, 1 bit: queue empty.
REQ-015 The block SHALL have port fifo_full, output, 1 bit: queue full.
REQ-016 The block SHALL have port fifo_count, output, $clog2(FIFO_DEPTH)+1 bits: number of queued bytes.
REQ-017 The block SHALL have port overflow, output, 1 bit: sticky flag, set when a push is dropped.
REQ-018 The block SHALL have port idle, output, 1 bit: high when state is S_IDLE and fifo_empty is high.

Function
REQ-019 The controller SHALL implement a FIFO_DEPTH-entry circular FIFO with wrap-around read and write pointers and a separate count; fifo_full SHALL be high exactly when count = FIFO_DEPTH, and fifo_empty exactly when count = 0.
REQ-020 A push SHALL be accepted at the clock edge where wr_en=1 and flush=0, provided either count < FIFO_DEPTH or a pop occurs at that same edge; when both push and pop occur, count SHALL be unchanged.
REQ-021 A push with wr_en=1, flush=0 and the FIFO full with no pop at that edge SHALL be dropped, and overflow SHALL set at that edge.
REQ-022 overflow_clr SHALL clear overflow; when a set and a clear occur at the same edge, set SHALL win.
REQ-023 flush SHALL zero the pointers and count at the next edge, and SHALL take priority over any push or pop at that edge.
REQ-024 A push dropped because of flush SHALL NOT set overflow.
REQ-025 flush SHALL NOT abort a frame already started.
REQ-026 The FSM SHALL have states S_IDLE, S_START, S_WAIT_ACK and S_WAIT_DONE.
REQ-027 S_IDLE SHALL go to S_START when tx_enable=1, fifo_empty=0, tx_busy=0 and flush=0; on this transition, tx_data SHALL load the FIFO head.
REQ-028 S_START SHALL assert tx_start for exactly one cycle, pop the FIFO at the exiting edge, and go unconditionally to S_WAIT_ACK.
REQ-029 S_WAIT_ACK SHALL go to S_WAIT_DONE when tx_busy=1.
REQ-030 S_WAIT_ACK SHALL return to S_IDLE if tx_busy stays low for ACK_TIMEOUT cycles, with the byte counted as consumed.
REQ-031 S_WAIT_DONE SHALL go to S_IDLE when tx_busy=0.
REQ-032 tx_start SHALL be high only while in S_START.
REQ-033 tx_data SHALL hold its value from load until the next load.
REQ-034 Latency: with the controller idle, tx_enable=1 and tx_busy=0, a push captured at edge E0 SHALL make the FSM enter S_START at E1, assert tx_start between E1 and E2, and pop at E2.
REQ-035 Consecutive frames SHALL be separated by at least one S_IDLE cycle after tx_busy falls.
REQ-036 Deasserting tx_enable SHALL only prevent new starts and SHALL NOT affect a frame in progress.

Reset
REQ-037 Asserting reset SHALL immediately force: state S_IDLE; pointers and count 0; tx_start 0; tx_data 0; overflow 0; fifo_empty 1; fifo_full 0; idle 1.
REQ-038 Reset asserted mid-frame SHALL discard queued data; no tx_start SHALL occur until reset is released and a new push is made.

Verification
REQ-039 Push 0xA5 into an idle controller with tx_enable=1 and tx_busy=0 -> tx_start is a single pulse at E1, tx_data=0xA5, and fifo_count returns to 0 at E2.
REQ-040 Push 0x11,0x22,0x33 back-to-back with a transmitter model (busy high for 10 cycles from start) -> three tx_start pulses in order 0x11,0x22,0x33, each only after tx_busy has fallen.
REQ-041 With tx_enable=0, push 9 bytes at FIFO_DEPTH=8 -> fifo_full=1, fifo_count=8, overflow=1, and the 9th byte is absent on drain.
REQ-042 With the FIFO full and in S_START, push at the pop edge -> push accepted, fifo_count stays 8, overflow stays 0.
REQ-043 Assert flush and wr_en together with 3 bytes queued during S_WAIT_DONE -> count 0, overflow 0, and the current frame completes.
REQ-044 With tx_busy tied low after tx_start -> S_WAIT_ACK times out after 4 cycles to S_IDLE, and the next byte then starts.

Source files
------------

// File: rtl/uart_tx_controller.sv
// uart_tx_controller: queues CPU bytes in a circular FIFO and hands them one at a time
// to a UART transmitter, tracking its busy handshake with an acknowledge timeout.
module uart_tx_controller #(
   parameter int DATA_WIDTH = 8,
   parameter int FIFO_DEPTH = 8,
   parameter int ACK_TIMEOUT = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          wr_en,
   input  logic [DATA_WIDTH-1:0]         wr_data,
   input  logic                          flush,
   input  logic                          tx_enable,
   input  logic                          overflow_clr,
   input  logic                          tx_busy,
   output logic                          tx_start,
   output logic [DATA_WIDTH-1:0]         tx_data,
   output logic                          fifo_empty,
   output logic                          fifo_full,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          overflow,
   output logic                          idle
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam int TW = $clog2(ACK_TIMEOUT + 1);
   localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);
   typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT_ACK, S_WAIT_DONE} state_t;
   state_t state;
   logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [TW-1:0] timer;
   logic pop, push, drop;
   assign fifo_full = fifo_count == FULL_COUNT;
   assign fifo_empty = fifo_count == '0;
   assign idle = state == S_IDLE && fifo_empty;
   // the head leaves the queue on the edge that ends the start strobe; flush overrides it
   assign pop = state == S_START && !flush;
   assign push = wr_en && !flush && (!fifo_full || pop);
   assign drop = wr_en && !flush && fifo_full && !pop;
   always_ff @(posedge clk)
      if (push) mem[wr_ptr] <= wr_data;
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         fifo_count <= '0;
         overflow <= 1'b0;
      end else begin
         if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fifo_count <= '0;
         end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            fifo_count <= fifo_count + CW'(push) - CW'(pop);
         end
         overflow <= drop || (overflow && !overflow_clr);
      end
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state <= S_IDLE;
         tx_start <= 1'b0;
         tx_data <= '0;
         timer <= '0;
      end else
         case (state)
            S_IDLE:
               if (tx_enable && !fifo_empty && !tx_busy && !flush) begin
                  state <= S_START;
                  tx_start <= 1'b1;
                  tx_data <= mem[rd_ptr];
               end
            S_START: begin
               state <= S_WAIT_ACK;
               tx_start <= 1'b0;
               timer <= '0;
            end
            S_WAIT_ACK:
               if (tx_busy) state <= S_WAIT_DONE;
               else if (timer == TW'(ACK_TIMEOUT - 1)) state <= S_IDLE;
               else timer <= timer + TW'(1);
            S_WAIT_DONE:
               if (!tx_busy) state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
endmodule

// File: tb/tb_uart_tx_controller.sv
// tb_uart_tx_controller: directed and randomized checks of uart_tx_controller against a
// queue-based reference model and a simple transmitter responder.
module tb_uart_tx_controller;
   localparam int DW = 8;
   localparam int DEPTH = 8;
   localparam int ACK = 4;
   logic clk = 0, reset = 0, wr_en = 0, flush = 0, tx_enable = 0, overflow_clr = 0, tx_busy = 0;
   logic [DW-1:0] wr_data = '0;
   logic tx_start, fifo_empty, fifo_full, overflow, idle;
   logic [DW-1:0] tx_data;
   logic [$clog2(DEPTH):0] fifo_count;
   int vectors = 0, miscompares = 0;
   logic [DW-1:0] q[$];
   bit m_start, m_act, m_acked, m_ovf;
   int m_left;
   logic [DW-1:0] m_data;
   int lat = 1, len = 10, cd = 0, left = 0, cyc = 0;
   logic [DW-1:0] started[$];
   int start_cyc[$];

   always #5 clk = ~clk;

   uart_tx_controller #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .ACK_TIMEOUT(ACK)) dut (
      .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .flush(flush),
      .tx_enable(tx_enable), .overflow_clr(overflow_clr), .tx_busy(tx_busy),
      .tx_start(tx_start), .tx_data(tx_data), .fifo_empty(fifo_empty), .fifo_full(fifo_full),
      .fifo_count(fifo_count), .overflow(overflow), .idle(idle)
   );

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_start = 0; m_act = 0; m_acked = 0; m_ovf = 0; m_left = 0; m_data = '0;
      cd = 0; left = 0; tx_busy = 0;
   endtask

   // one clock edge of the reference behaviour, using the inputs held across that edge
   task automatic model_edge();
      bit pop, nstart, ovf_set;
      pop = m_start;
      ovf_set = 0;
      nstart = !m_start && !m_act && tx_enable && q.size() != 0 && !tx_busy && !flush;
      if (nstart) m_data = q[0];
      if (m_start) begin
         m_act = 1; m_acked = 0; m_left = ACK;
      end else if (m_act) begin
         if (!m_acked) begin
            if (tx_busy) m_acked = 1;
            else begin
               m_left--;
               if (m_left == 0) m_act = 0;
            end
         end else if (!tx_busy) m_act = 0;
      end
      if (flush) q.delete();
      else begin
         if (pop && q.size() > 0) void'(q.pop_front());
         if (wr_en) begin
            if (q.size() < DEPTH) q.push_back(wr_data);
            else ovf_set = 1;
         end
      end
      m_ovf = ovf_set || (m_ovf && !overflow_clr);
      m_start = nstart;
   endtask

   task automatic check_all();
      chk("tx_start", tx_start, m_start);
      chk("tx_data", tx_data, m_data);
      chk("fifo_count", fifo_count, q.size());
      chk("fifo_full", fifo_full, q.size() == DEPTH);
      chk("fifo_empty", fifo_empty, q.size() == 0);
      chk("overflow", overflow, m_ovf);
      chk("idle", idle, !m_start && !m_act && q.size() == 0);
   endtask

   // transmitter responder: busy rises lat cycles after the start strobe, for len cycles
   task automatic xmit();
      if (m_start) begin
         cd = lat; left = len;
      end
      if (cd > 0) begin
         cd--; tx_busy = 0;
      end else if (left > 0) begin
         tx_busy = 1; left--;
      end else tx_busy = 0;
   endtask

   task automatic step();
      @(posedge clk);
      cyc++;
      if (reset) model_reset();
      else model_edge();
      #1;
      check_all();
      if (tx_start === 1'b1) begin
         started.push_back(tx_data);
         start_cyc.push_back(cyc);
      end
      if (!reset) xmit();
   endtask

   task automatic push(logic [DW-1:0] d);
      wr_en = 1; wr_data = d;
      step();
      wr_en = 0;
   endtask

   initial begin
      model_reset();
      #1 reset = 1;
      #1 check_all();
      step(); step();
      reset = 0;
      step(); step();
      // single byte latency
      tx_enable = 1; lat = 1; len = 3;
      push(8'hA5);
      chk("a5_count_e0", fifo_count, 1);
      step();
      chk("a5_start_e1", tx_start, 1);
      chk("a5_data_e1", tx_data, 8'hA5);
      step();
      chk("a5_count_e2", fifo_count, 0);
      chk("a5_start_low_e2", tx_start, 0);
      repeat (10) step();
      // three back-to-back frames with a 10-cycle busy transmitter
      started.delete(); len = 10;
      push(8'h11); push(8'h22); push(8'h33);
      repeat (60) step();
      chk("seq_n", started.size(), 3);
      for (int i = 0; i < 3 && i < started.size(); i++) chk("seq_data", started[i], 8'h11 * (i + 1));
      // fill while disabled, overflow on the ninth push
      tx_enable = 0;
      for (int i = 1; i <= 9; i++) push(DW'(i));
      chk("fill_full", fifo_full, 1);
      chk("fill_count", fifo_count, 8);
      chk("fill_ovf", overflow, 1);
      wr_en = 1; wr_data = 8'h09; overflow_clr = 1;
      step();
      wr_en = 0; overflow_clr = 0;
      chk("ovf_set_wins", overflow, 1);
      overflow_clr = 1;
      step();
      overflow_clr = 0;
      chk("ovf_cleared", overflow, 0);
      // push at the pop edge while full
      started.delete(); len = 3;
      tx_enable = 1;
      step();
      chk("full_start", tx_start, 1);
      push(8'h99);
      chk("full_pop_push_count", fifo_count, 8);
      chk("full_pop_push_ovf", overflow, 0);
      repeat (100) step();
      chk("drain_n", started.size(), 9);
      for (int i = 0; i < 9 && i < started.size(); i++) chk("drain_data", started[i], i < 8 ? DW'(i + 1) : 8'h99);
      // flush with push during an active frame
      started.delete(); len = 10;
      push(8'h44);
      for (int k = 0; k < 20 && !(m_act && m_acked); k++) step();
      tx_enable = 0;
      push(8'hB1); push(8'hB2); push(8'hB3);
      chk("pre_flush_count", fifo_count, 3);
      flush = 1; wr_en = 1; wr_data = 8'hEE;
      step();
      flush = 0; wr_en = 0;
      chk("flush_count", fifo_count, 0);
      chk("flush_ovf", overflow, 0);
      chk("flush_frame_alive", idle, 0);
      tx_enable = 1;
      repeat (30) step();
      chk("flush_frames", started.size(), 1);
      // acknowledge timeout
      started.delete(); start_cyc.delete(); len = 0;
      push(8'h55); push(8'h66);
      repeat (30) step();
      chk("timeout_n", started.size(), 2);
      if (start_cyc.size() == 2) chk("timeout_gap", start_cyc[1] - start_cyc[0], 6);
      // reset in the middle of a frame
      len = 10;
      push(8'h77); push(8'h78); push(8'h79);
      step(); step();
      #2 reset = 1;
      #1 model_reset();
      check_all();
      step(); step();
      reset = 0;
      started.delete();
      repeat (10) step();
      chk("post_reset_starts", started.size(), 0);
      // randomized traffic
      for (int i = 0; i < 2000; i++) begin
         if (i % 64 == 0) tx_enable = $urandom_range(0, 3) != 0;
         wr_en = $urandom_range(0, 9) < 4;
         wr_data = DW'($urandom);
         flush = $urandom_range(0, 49) == 0;
         overflow_clr = $urandom_range(0, 19) == 0;
         lat = $urandom_range(1, 6);
         len = $urandom_range(0, 8);
         step();
      end
      wr_en = 0; flush = 0; overflow_clr = 0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
